// File: rtl/parking_gate_if.sv
// Parking gate sensor/event bundle.
// master drives requests and space flags, slave drives barriers and events.
interface parking_gate_if;
  logic entry_req;
  logic entry_is_uni;
  logic exit_req;
  logic exit_is_uni;
  logic is_vacated_space;
  logic is_uni_vacated_space;
  logic car_entered;
  logic is_uni_car_entered;
  logic car_exited;
  logic is_uni_car_exited;
  logic entry_barrier_open;
  logic exit_barrier_open;
  logic entry_denied;

  modport master (
    output entry_req, entry_is_uni,
    output exit_req, exit_is_uni,
    output is_vacated_space,
    output is_uni_vacated_space,
    input  car_entered, is_uni_car_entered,
    input  car_exited, is_uni_car_exited,
    input  entry_barrier_open,
    input  exit_barrier_open,
    input  entry_denied
  );

  modport slave (
    input  entry_req, entry_is_uni,
    input  exit_req, exit_is_uni,
    input  is_vacated_space,
    input  is_uni_vacated_space,
    output car_entered, is_uni_car_entered,
    output car_exited, is_uni_car_exited,
    output entry_barrier_open,
    output exit_barrier_open,
    output entry_denied
  );
endinterface

// File: rtl/parking_gate_sequencer.sv
// Entry/exit barrier sequencer with debounce and space check.
// Exit events win a same-cycle collision; entry waits one cycle.
module parking_gate_sequencer #(
  parameter int DEBOUNCE    = 3,
  parameter int OPEN_CYCLES = 4
) (
  input logic           clk,
  input logic           rst,
  parking_gate_if.slave gate
);

  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE - 1);
  localparam logic [7:0] OC_LAST = 8'(OPEN_CYCLES - 1);

  typedef enum logic [2:0] {
    EN_IDLE, EN_DEB, EN_CHECK, EN_OPEN,
    EN_PULSE, EN_DENY, EN_CLEAR
  } en_state_t;

  typedef enum logic [2:0] {
    EX_IDLE, EX_DEB, EX_OPEN,
    EX_PULSE, EX_CLEAR
  } ex_state_t;

  en_state_t  en_state, en_next;
  logic [3:0] en_dcnt, en_dcnt_n;
  logic [7:0] en_ocnt, en_ocnt_n;
  logic       en_uni, en_uni_n;

  ex_state_t  ex_state, ex_next;
  logic [3:0] ex_dcnt, ex_dcnt_n;
  logic [7:0] ex_ocnt, ex_ocnt_n;
  logic       ex_uni, ex_uni_n;

  logic       en_pass;

  // Entry FSM state and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_state <= EN_IDLE;
      en_dcnt  <= '0;
      en_ocnt  <= '0;
      en_uni   <= 1'b0;
    end else begin
      en_state <= en_next;
      en_dcnt  <= en_dcnt_n;
      en_ocnt  <= en_ocnt_n;
      en_uni   <= en_uni_n;
    end
  end

  // Exit FSM state and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_state <= EX_IDLE;
      ex_dcnt  <= '0;
      ex_ocnt  <= '0;
      ex_uni   <= 1'b0;
    end else begin
      ex_state <= ex_next;
      ex_dcnt  <= ex_dcnt_n;
      ex_ocnt  <= ex_ocnt_n;
      ex_uni   <= ex_uni_n;
    end
  end

  // Entry next state: debounce, space check, open, event
  always_comb begin
    en_next   = en_state;
    en_dcnt_n = en_dcnt;
    en_ocnt_n = en_ocnt;
    en_uni_n  = en_uni;
    en_pass   = en_uni ? gate.is_uni_vacated_space
                       : gate.is_vacated_space;
    unique case (en_state)
      EN_IDLE: begin
        en_dcnt_n = '0;
        en_ocnt_n = '0;
        en_uni_n  = 1'b0;
        if (gate.entry_req) en_next = EN_DEB;
      end
      EN_DEB: begin
        if (!gate.entry_req) begin
          en_next   = EN_IDLE;
          en_dcnt_n = '0;
        end else if (en_dcnt == DB_LAST) begin
          en_next   = EN_CHECK;
          en_dcnt_n = '0;
          en_uni_n  = gate.entry_is_uni;
        end else begin
          en_dcnt_n = en_dcnt + 4'd1;
        end
      end
      EN_CHECK: begin
        en_ocnt_n = '0;
        en_next   = en_pass ? EN_OPEN : EN_DENY;
      end
      EN_OPEN: begin
        if (!gate.entry_req) begin
          en_next = EN_IDLE;
        end else if (en_ocnt == OC_LAST) begin
          en_next = EN_PULSE;
        end else begin
          en_ocnt_n = en_ocnt + 8'd1;
        end
      end
      EN_PULSE: begin
        if (ex_state != EX_PULSE) en_next = EN_CLEAR;
      end
      EN_DENY: begin
        if (!gate.entry_req) en_next = EN_IDLE;
      end
      EN_CLEAR: begin
        if (!gate.entry_req) en_next = EN_IDLE;
      end
      default: en_next = EN_IDLE;
    endcase
  end

  // Exit next state: debounce, open, event
  always_comb begin
    ex_next   = ex_state;
    ex_dcnt_n = ex_dcnt;
    ex_ocnt_n = ex_ocnt;
    ex_uni_n  = ex_uni;
    unique case (ex_state)
      EX_IDLE: begin
        ex_dcnt_n = '0;
        ex_ocnt_n = '0;
        ex_uni_n  = 1'b0;
        if (gate.exit_req) ex_next = EX_DEB;
      end
      EX_DEB: begin
        if (!gate.exit_req) begin
          ex_next   = EX_IDLE;
          ex_dcnt_n = '0;
        end else if (ex_dcnt == DB_LAST) begin
          ex_next   = EX_OPEN;
          ex_dcnt_n = '0;
          ex_ocnt_n = '0;
          ex_uni_n  = gate.exit_is_uni;
        end else begin
          ex_dcnt_n = ex_dcnt + 4'd1;
        end
      end
      EX_OPEN: begin
        if (!gate.exit_req) begin
          ex_next = EX_IDLE;
        end else if (ex_ocnt == OC_LAST) begin
          ex_next = EX_PULSE;
        end else begin
          ex_ocnt_n = ex_ocnt + 8'd1;
        end
      end
      EX_PULSE: ex_next = EX_CLEAR;
      EX_CLEAR: begin
        if (!gate.exit_req) ex_next = EX_IDLE;
      end
      default: ex_next = EX_IDLE;
    endcase
  end

  // Outputs decode from state so reset clears them at once
  always_comb begin
    gate.entry_barrier_open = (en_state == EN_OPEN);
    gate.exit_barrier_open  = (ex_state == EX_OPEN);
    gate.car_exited         = (ex_state == EX_PULSE);
    gate.is_uni_car_exited  = (ex_state == EX_PULSE)
                              && ex_uni;
    gate.car_entered        = (en_state == EN_PULSE)
                              && (ex_state != EX_PULSE);
    gate.is_uni_car_entered = (en_state == EN_PULSE)
                              && (ex_state != EX_PULSE)
                              && en_uni;
    gate.entry_denied       = (en_state == EN_DENY)
                              && gate.entry_req;
  end

endmodule

// File: tb/tb_parking_gate_sequencer.sv
// Directed bench for parking_gate_sequencer.
// Cycle k is observed at the negedge after the k-th sampling edge.
module tb_parking_gate_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   ent_cnt = 0;
  int   uni_ent = 0;
  int   overlap = 0;
  int   orphan = 0;

  parking_gate_if gi();

  parking_gate_sequencer #(
    .DEBOUNCE(3),
    .OPEN_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .gate(gi.slave)
  );

  always #5 clk = ~clk;

  // {eb, ce, ue, dn, xb, cx, ux}
  function automatic logic [6:0] outs();
    return {gi.entry_barrier_open, gi.car_entered,
            gi.is_uni_car_entered, gi.entry_denied,
            gi.exit_barrier_open, gi.car_exited,
            gi.is_uni_car_exited};
  endfunction

  task automatic chk(input string tag,
                     input logic [6:0] exp);
    logic [6:0] obs;
    obs = outs();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b",
             tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag,
                         input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  // Event monitor for the long run and global invariants
  always @(negedge clk) begin
    if (gi.car_entered === 1'b1) ent_cnt++;
    if (gi.is_uni_car_entered === 1'b1) uni_ent++;
    if (gi.car_entered === 1'b1 && gi.car_exited === 1'b1)
      overlap++;
    if ((gi.is_uni_car_entered === 1'b1 && gi.car_entered !== 1'b1) ||
        (gi.is_uni_car_exited === 1'b1 && gi.car_exited !== 1'b1))
      orphan++;
  end

  initial begin
    rst = 1'b1;
    gi.entry_req = 1'b0;
    gi.entry_is_uni = 1'b0;
    gi.exit_req = 1'b0;
    gi.exit_is_uni = 1'b0;
    gi.is_vacated_space = 1'b1;
    gi.is_uni_vacated_space = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset", 7'b0);

    // Uni car held from the first edge after reset
    gi.entry_is_uni = 1'b1;
    gi.entry_req = 1'b1;
    rst = 1'b0;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      chk($sformatf("t1_c%0d", k),
          {(k >= 4 && k <= 7), (k == 8), (k == 8), 4'b0});
    end
    gi.entry_req = 1'b0;
    gi.entry_is_uni = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t1_idle", 7'b0);

    // Glitch: high 2, low 1, then held
    for (int k = 0; k < 14; k++) begin
      gi.entry_req = (k != 2);
      @(negedge clk);
      chk($sformatf("t2_c%0d", k),
          {(k >= 7 && k <= 10), (k == 11), 5'b0});
    end
    gi.entry_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t2_idle", 7'b0);

    // No free space: denied, late space ignored
    gi.is_vacated_space = 1'b0;
    gi.entry_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("t3_c%0d", k),
          {3'b0, (k >= 4), 3'b0});
      if (k == 6) gi.is_vacated_space = 1'b1;
    end
    gi.entry_req = 1'b0;
    #1;
    chk("t3_drop", 7'b0);
    @(negedge clk);
    @(negedge clk);
    chk("t3_idle", 7'b0);

    // Entry and exit collide in PULSE at cycle 8
    gi.exit_is_uni = 1'b1;
    for (int k = 0; k < 12; k++) begin
      gi.entry_req = 1'b1;
      gi.exit_req = (k >= 1);
      @(negedge clk);
      chk($sformatf("t4_c%0d", k),
          {(k >= 4 && k <= 7), (k == 9), 2'b0,
           (k >= 4 && k <= 7), (k == 8), (k == 8)});
    end
    gi.entry_req = 1'b0;
    gi.exit_req = 1'b0;
    gi.exit_is_uni = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t4_idle", 7'b0);

    // Reset in the middle of OPEN, then a fresh full sequence
    gi.entry_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("t5_c%0d", k),
          {(k >= 4), 6'b0});
    end
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async", 7'b0);
    @(negedge clk);
    @(negedge clk);
    chk("t5_held", 7'b0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("t5_r%0d", k),
          {(k >= 4 && k <= 7), (k == 8), 5'b0});
    end
    gi.entry_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_idle", 7'b0);

    // 202 back-to-back free-car entries
    #1;
    ent_cnt = 0;
    uni_ent = 0;
    for (int n = 0; n < 202; n++) begin
      for (int k = 0; k < 12; k++) begin
        gi.entry_req = (k < 10);
        @(negedge clk);
      end
    end
    @(negedge clk);
    #1;
    chk_int("t6_entries", ent_cnt, 202);
    chk_int("t6_uni", uni_ent, 0);
    chk_int("overlap", overlap, 0);
    chk_int("orphan_uni", orphan, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/parking_gate_sequencer.md
PARKING_GATE_SEQUENCER -- requirements
Module: parking_gate_sequencer

Interface
REQ-001 Parameter: DEBOUNCE, 3, consecutive high samples of a gate request before it is accepted (range 1-15).
REQ-002 Parameter: OPEN_CYCLES, 4, cycles a barrier is held open (range 1-255).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: entry_req  input  1  entry-gate loop sensor level, car present.
REQ-006 Port: entry_is_uni  input  1  entry car is a university car; sampled with entry_req.
REQ-007 Port: exit_req  input  1  exit-gate loop sensor level.
REQ-008 Port: exit_is_uni  input  1  exiting car is a university car.
REQ-009 Port: is_vacated_space  input  1  free-car space available, from the parking controller.
REQ-010 Port: is_uni_vacated_space  input  1  university space available, from the parking controller.
REQ-011 Port: car_entered / is_uni_car_entered  output  1 each  one-cycle entry event to the parking controller.
REQ-012 Port: car_exited / is_uni_car_exited  output  1 each  one-cycle exit event to the parking controller.
REQ-013 Port: entry_barrier_open, exit_barrier_open  output  1 each  barrier drive, high = open.
REQ-014 Port: entry_denied  output  1  entry refused for lack of space.

Function
REQ-015 Entry FSM SHALL have states IDLE, DEBOUNCE, CHECK, OPEN, PULSE, DENY, CLEAR.
REQ-016 IDLE->DEBOUNCE on entry_req=1; DEBOUNCE counts consecutive high samples; any low sample returns to IDLE with count cleared, no event.
REQ-017 After DEBOUNCE high samples -> CHECK; entry_is_uni latched on CHECK entry and held until IDLE.
REQ-018 CHECK (one cycle): uni car needs is_uni_vacated_space=1, free car needs is_vacated_space=1; pass -> OPEN, fail -> DENY.
REQ-019 OPEN: entry_barrier_open=1 for exactly OPEN_CYCLES cycles, then PULSE; entry_req dropping during OPEN aborts to IDLE, barrier closes next cycle, no event.
REQ-020 PULSE: car_entered=1 and is_uni_car_entered=latched type for exactly one cycle, then CLEAR.
REQ-021 DENY: entry_denied=1 while entry_req=1; entry_req=0 -> IDLE; space appearing during DENY is ignored.
REQ-022 CLEAR: wait for entry_req=0, then IDLE; one car presence yields at most one event.
REQ-023 Exit FSM SHALL be identical minus CHECK and DENY (DEBOUNCE->OPEN directly), driving exit_barrier_open, car_exited, is_uni_car_exited.
REQ-024 Entry and exit events SHALL never assert in the same cycle; if both FSMs reach PULSE together, exit fires first, entry PULSE held one extra cycle.
REQ-025 is_uni_car_* SHALL be 0 whenever the matching car_* is 0.
REQ-026 Latency: barrier rises DEBOUNCE+1 cycles after first high sample of a request (entry; DEBOUNCE for exit), event pulse follows the cycle after barrier falls.
REQ-027 Entry and exit FSMs SHALL operate concurrently and independently except REQ-024.

Reset
REQ-028 rst=1 SHALL immediately force both FSMs to IDLE, clear counters and latched types, drive all outputs 0, regardless of clock.
REQ-029 Reset mid-OPEN or mid-PULSE SHALL drop barrier and event outputs asynchronously; no event emitted after deassertion until a new full debounce completes.
REQ-030 First request is sampled on the first rising edge after rst deasserts.

Verification
REQ-031 Defaults, is_uni_vacated_space=1, entry_req=1 and entry_is_uni=1 held from cycle 0 -> barrier open cycles 4-7, car_entered=is_uni_car_entered=1 in cycle 8 only, nothing more until entry_req falls.
REQ-032 entry_req high 2 cycles, low 1, high 2 -> no barrier, no event; held thereafter -> normal sequence from the restart.
REQ-033 is_vacated_space=0, free car held -> entry_denied=1 from cycle 4 until entry_req=0; barrier never opens; no car_entered.
REQ-034 Entry and exit requests aligned so both reach PULSE in cycle N -> car_exited in N, car_entered in N+1, never overlapping.
REQ-035 rst asserted during cycle 5 of entry OPEN -> barrier 0 immediately; no car_entered; new request after reset completes full 8-cycle sequence.
REQ-036 202 back-to-back free-car entries (req high 10 cycles, low 2) with space available -> exactly 202 car_entered pulses, is_uni_car_entered always 0.
